// File: rtl/bus_decode_ws.sv
// bus_decode_ws: multiplexed-bus address latch, chip-select decoder and
// wait-state generator.
//
// An address phase (ALE high) latches {A,AD} and IOM. When ALE drops, the
// latched address is decoded against NCH base/mask windows. The first
// strobe (RD or WR low) then asserts the winning chip select, holds READY
// low for that channel's wait count and keeps CS up until both strobes
// return high. A strobe to an unmapped address pulses BUSERR instead.
// ALE during an active cycle aborts it.
//
// Ports:
//   CLK      bus clock, rising edge
//   RESET    asynchronous, active-high reset
//   ALE      address latch enable
//   IOM      1 = IO cycle, 0 = memory cycle (latched with the address)
//   RD, WR   active-low read/write strobes
//   A        upper address bits (AW-DW)
//   AD       multiplexed address/data low bits
//   Address  latched bus address
//   CS       one-hot chip select, active high
//   READY    0 inserts a wait state
//   BUSERR   one-cycle pulse for a strobed cycle with no decode hit
//
// Packed per-channel parameters put channel 0 in the least-significant
// slice, so in the defaults channel 0 is the rightmost entry of each list.

module bus_decode_ws_chan #(
  parameter int            AW      = 20,
  parameter logic [AW-1:0] BASE_C  = '0,
  parameter logic [AW-1:0] MASK_C  = '0,
  parameter logic          IS_IO_C = 1'b0
) (
  input  logic [AW-1:0] addr,
  input  logic          iom,
  output logic          hit
);
  assign hit = (((addr ^ BASE_C) & MASK_C) == '0) && (iom == IS_IO_C);
endmodule

module bus_decode_ws #(
  parameter int                NCH   = 4,
  parameter int                AW    = 20,
  parameter int                DW    = 8,
  parameter logic [NCH*AW-1:0] BASE  = {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
  parameter logic [NCH*AW-1:0] MASK  = {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NCH-1:0]    IS_IO = 4'b1100,
  parameter logic [NCH*4-1:0]  WAIT  = {4'd3, 4'd1, 4'd2, 4'd0}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ALE,
  input  logic             IOM,
  input  logic             RD,
  input  logic             WR,
  input  logic [AW-DW-1:0] A,
  input  logic [DW-1:0]    AD,
  output logic [AW-1:0]    Address,
  output logic [NCH-1:0]   CS,
  output logic             READY,
  output logic             BUSERR
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, DECODED, WAITST, XFER} state_t;

  state_t         state, state_d;
  logic           iom_q;
  logic [NCH-1:0] hit_vec;
  logic           hit_any;
  logic [IW-1:0]  hit_idx;
  logic           hit_vld_q;
  logic [IW-1:0]  hit_idx_q;
  logic [NCH-1:0] cs_hit;
  logic [NCH-1:0] cs_d;
  logic [3:0]     cnt, cnt_d;
  logic           buserr_d;
  logic           strobe;
  logic [3:0]     wait_tbl [NCH];

  // Both strobes low together is still a single strobe.
  assign strobe = !RD || !WR;
  assign READY  = (state != WAITST);

  // Per-channel window compare.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    bus_decode_ws_chan #(
      .AW      (AW),
      .BASE_C  (BASE[gi*AW +: AW]),
      .MASK_C  (MASK[gi*AW +: AW]),
      .IS_IO_C (IS_IO[gi])
    ) u_chan (
      .addr (Address),
      .iom  (iom_q),
      .hit  (hit_vec[gi])
    );
    assign wait_tbl[gi] = WAIT[gi*4 +: 4];
  end

  // Priority select: scanning downward lets the lowest hit overwrite.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    cs_hit            = '0;
    cs_hit[hit_idx_q] = 1'b1;
  end

  // Address phase latch; transparent on every edge while ALE is high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Address <= '0;
      iom_q   <= 1'b0;
    end else if (ALE) begin
      Address <= {A, AD};
      iom_q   <= IOM;
    end
  end

  // Decode result frozen when the address phase ends.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_vld_q <= 1'b0;
      hit_idx_q <= '0;
    end else if (state == ADDR && !ALE) begin
      hit_vld_q <= hit_any;
      hit_idx_q <= hit_idx;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      CS     <= '0;
      BUSERR <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      CS     <= cs_d;
      BUSERR <= buserr_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cs_d     = CS;
    buserr_d = 1'b0;
    if (ALE && state != IDLE) begin
      // A new address phase abandons whatever cycle was in flight.
      state_d = ADDR;
      cnt_d   = '0;
      cs_d    = '0;
    end else begin
      unique case (state)
        IDLE: if (ALE) state_d = ADDR;
        ADDR: state_d = DECODED;
        DECODED: begin
          if (strobe) begin
            if (hit_vld_q) begin
              cnt_d   = wait_tbl[hit_idx_q];
              cs_d    = cs_hit;
              state_d = (wait_tbl[hit_idx_q] != 4'd0) ? WAITST : XFER;
            end else begin
              buserr_d = 1'b1;
              cs_d     = '0;
              state_d  = XFER;
            end
          end
        end
        WAITST: begin
          // Leave on the edge where the count reaches zero so READY is
          // low for exactly the loaded number of cycles.
          if (cnt <= 4'd1) begin
            cnt_d   = '0;
            state_d = XFER;
          end else begin
            cnt_d = cnt - 4'd1;
          end
        end
        XFER: begin
          if (!strobe) begin
            state_d = IDLE;
            cs_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cs_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decode_ws.sv
// Testbench for bus_decode_ws: directed bus cycles followed by randomized
// ones. The driver pushes the expected observation of each cycle (chip
// select, READY-low count, CS-high count, BUSERR count, address) into a
// queue; a monitor on the falling edge groups active bus cycles and
// compares them against the queue.

module tb_bus_decode_ws;
  logic        CLK = 1'b0;
  logic        RESET, ALE, IOM, RD, WR;
  logic [11:0] A;
  logic [7:0]  AD;
  logic [19:0] Address;
  logic [3:0]  CS;
  logic        READY, BUSERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bus_decode_ws dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ALE     (ALE),
    .IOM     (IOM),
    .RD      (RD),
    .WR      (WR),
    .A       (A),
    .AD      (AD),
    .Address (Address),
    .CS      (CS),
    .READY   (READY),
    .BUSERR  (BUSERR)
  );

  typedef struct {
    logic [3:0]  cs;
    int          low;
    int          cyc;
    int          berr;
    logic [19:0] addr;
  } obs_t;

  obs_t exp_q[$];

  // Reference address map, channel index order.
  logic [19:0] m_base [4] = '{20'h00000, 20'h80000, 20'h0FF00, 20'h01C00};
  logic [19:0] m_mask [4] = '{20'h80000, 20'h80000, 20'h0FFF0, 20'h0FE00};
  bit          m_io   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int          m_wait [4] = '{0, 2, 1, 3};

  function automatic int ref_hit(input logic [19:0] a, input logic iom);
    for (int i = 0; i < 4; i++)
      if ((((a ^ m_base[i]) & m_mask[i]) == 20'h0) && (iom == m_io[i]))
        return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // kind: 0 = read, 1 = write, 2 = both strobes. abort_k > 0 leaves the
  // strobe low after abort_k wait cycles; the next call's ALE aborts it.
  task automatic do_cycle(input logic [19:0] addr, input logic iom, input int kind,
                          input int gap, input int extra, input int abort_k);
    int   h;
    obs_t e;
    ALE = 1'b1; A = addr[19:8]; AD = addr[7:0]; IOM = iom; RD = 1'b1; WR = 1'b1;
    step();
    ALE = 1'b0; AD = 8'($urandom); IOM = 1'($urandom);
    step();
    repeat (gap) step();
    h = ref_hit(addr, iom);
    RD = (kind == 1);
    WR = (kind == 0);
    e.addr = addr;
    if (h < 0) begin
      e.cs = 4'h0; e.low = 0; e.cyc = 0; e.berr = 1;
    end else begin
      e.cs = 4'(1 << h); e.berr = 0;
      if (abort_k > 0) begin
        e.low = abort_k; e.cyc = abort_k;
      end else begin
        e.low = m_wait[h]; e.cyc = m_wait[h] + 1 + extra;
      end
    end
    exp_q.push_back(e);
    if (abort_k > 0) begin
      repeat (abort_k) step();
    end else begin
      repeat ((h < 0 ? 0 : m_wait[h]) + 1 + extra) step();
      RD = 1'b1; WR = 1'b1;
      step();
    end
  endtask

  // Monitor: an active cycle is any cycle with CS set, READY low or BUSERR.
  obs_t cur;
  bit   in_obs = 1'b0;
  always @(negedge CLK) begin
    obs_t e;
    check("cs_onehot", 32'((CS & (CS - 4'd1)) != 4'd0), 32'd0);
    if (!RESET && (CS != 4'd0 || !READY || BUSERR)) begin
      if (!in_obs) begin
        in_obs   = 1'b1;
        cur.cs   = CS;
        cur.low  = 0;
        cur.cyc  = 0;
        cur.berr = 0;
        cur.addr = Address;
      end
      cur.cs   = cur.cs | CS;
      cur.cyc  = cur.cyc + int'(CS != 4'd0);
      cur.low  = cur.low + int'(!READY);
      cur.berr = cur.berr + int'(BUSERR);
    end else if (in_obs) begin
      in_obs = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_cycle", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("cs",         32'(cur.cs),   32'(e.cs));
        check("ready_low",  32'(cur.low),  32'(e.low));
        check("cs_cycles",  32'(cur.cyc),  32'(e.cyc));
        check("buserr_cyc", 32'(cur.berr), 32'(e.berr));
        check("address",    32'(cur.addr), 32'(e.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] addr;
    logic        iom;
    int          h, ab, sel;
    RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; A = '0; AD = '0;
    #3;
    check("rst_address", 32'(Address), 32'h0);
    check("rst_cs",      32'(CS),      32'h0);
    check("rst_ready",   32'(READY),   32'h1);
    check("rst_buserr",  32'(BUSERR),  32'h0);
    step(); step();
    RESET = 1'b0;
    step();

    // Directed cycles from the address map.
    do_cycle(20'h12345, 1'b0, 0, 0, 1, 0); step(); step();
    do_cycle(20'h9ABCD, 1'b0, 1, 1, 0, 0);
    do_cycle(20'h0FF05, 1'b1, 0, 0, 0, 0);
    do_cycle(20'h01C10, 1'b1, 0, 2, 1, 0);
    do_cycle(20'h00500, 1'b1, 0, 0, 1, 0); step();
    do_cycle(20'h9ABCD, 1'b0, 2, 0, 0, 0);
    // ALE during the wait states, then a normal cycle.
    do_cycle(20'h01C10, 1'b1, 0, 0, 0, 2);
    do_cycle(20'h0FF05, 1'b1, 1, 0, 0, 0);

    // Reset in the second wait state of a write to 9ABCD.
    ALE = 1'b1; A = 12'h9AB; AD = 8'hCD; IOM = 1'b0;
    step();
    ALE = 1'b0;
    step();
    WR = 1'b0;
    step(); step();
    exp_q.push_back('{cs: 4'b0010, low: 2, cyc: 2, berr: 0, addr: 20'h9ABCD});
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check("async_rst_cs",     32'(CS),     32'h0);
    check("async_rst_ready",  32'(READY),  32'h1);
    check("async_rst_buserr", 32'(BUSERR), 32'h0);
    step(); step();
    RESET = 1'b0;
    repeat (4) begin
      step();
      check("post_rst_cs",    32'(CS),    32'h0);
      check("post_rst_ready", 32'(READY), 32'h1);
    end
    WR = 1'b1;
    step();

    // Randomized cycles.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       begin addr = 20'($urandom); iom = 1'($urandom); end
        1:       begin addr = {16'h0FF0, 4'($urandom)}; iom = ($urandom_range(0, 3) != 0); end
        2:       begin addr = 20'h01C00 | 20'($urandom_range(0, 511)); iom = ($urandom_range(0, 3) != 0); end
        default: begin addr = 20'($urandom); iom = 1'b0; end
      endcase
      h  = ref_hit(addr, iom);
      ab = 0;
      if (h >= 0 && m_wait[h] >= 2 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, m_wait[h] - 1);
      do_cycle(addr, iom, $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), ab);
      if (ab == 0) repeat ($urandom_range(0, 2)) step();
    end

    RD = 1'b1; WR = 1'b1;
    repeat (6) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
